// File: rtl/coin_field.sv
`default_nettype none
// ============================================================================
// Module   : coin_field
// Purpose  : Coin slot manager for the two-player game: LFSR spawning, pickup
//            arbitration, optional expiry (COIN_EXPIRE_EN), saturating scores.
// Revision : 1.0 - initial release
// ============================================================================
module coin_field #(
    parameter int NUM_COINS     = 4,
    parameter int POS_W         = 10,
    parameter int FIELD_MAX     = 639,
    parameter int HIT_RADIUS    = 8,
    parameter int LIFE_TICKS    = 180,
    parameter int RESPAWN_TICKS = 60,
    parameter int SCORE_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [POS_W-1:0]           player_left,
    input  logic [POS_W-1:0]           player_right,
    output logic [NUM_COINS-1:0]       coin_active,
    output logic [NUM_COINS*POS_W-1:0] coin_pos,
    output logic                       collect_left,
    output logic                       collect_right,
    output logic [SCORE_W-1:0]         score_left,
    output logic [SCORE_W-1:0]         score_right
);

    localparam int                   c_RSP_W     = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [c_RSP_W-1:0]   c_RSP_LOAD  = c_RSP_W'(RESPAWN_TICKS - 1);
    localparam logic [c_RSP_W-1:0]   c_RSP_ONE   = c_RSP_W'(1);
    localparam logic [POS_W:0]       c_RADIUS    = (POS_W+1)'(HIT_RADIUS);
    localparam logic [POS_W-1:0]     c_FIELD_MAX = POS_W'(FIELD_MAX);
    localparam logic [POS_W-1:0]     c_FOLD      = POS_W'(FIELD_MAX + 1);
    localparam logic [SCORE_W-1:0]   c_SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]   c_SCORE_ONE = SCORE_W'(1);
    localparam logic [NUM_COINS-1:0] c_SLOT_ONE  = NUM_COINS'(1);

    logic [15:0]          r_lfsr;
    logic [NUM_COINS-1:0] r_active;
    logic [POS_W-1:0]     r_pos [NUM_COINS];
    logic [c_RSP_W-1:0]   r_rsp [NUM_COINS];
    logic                 r_collect_left;
    logic                 r_collect_right;
    logic [SCORE_W-1:0]   r_score_left;
    logic [SCORE_W-1:0]   r_score_right;

    logic [POS_W-1:0]     w_raw_pos;
    logic [POS_W-1:0]     w_spawn_pos;
    logic [POS_W:0]       w_dist_l [NUM_COINS];
    logic [POS_W:0]       w_dist_r [NUM_COINS];
    logic [NUM_COINS-1:0] w_hit_l;
    logic [NUM_COINS-1:0] w_hit_r;
    logic [NUM_COINS-1:0] w_first_l;
    logic [NUM_COINS-1:0] w_first_r;
    logic [NUM_COINS-1:0] w_same;
    logic [NUM_COINS-1:0] w_take_l;
    logic [NUM_COINS-1:0] w_take_r;
    logic [NUM_COINS-1:0] w_can_spawn;
    logic [NUM_COINS-1:0] w_spawn_oh;
    logic [NUM_COINS-1:0] w_expire;
    logic                 w_right_closer;
    logic                 w_win_l;
    logic                 w_win_r;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_raw_pos   = r_lfsr[POS_W-1:0];
    assign w_spawn_pos = (w_raw_pos > c_FIELD_MAX) ? (w_raw_pos - c_FOLD) : w_raw_pos;

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_slot
            assign w_dist_l[gi] = (player_left >= r_pos[gi])
                                ? ({1'b0, player_left} - {1'b0, r_pos[gi]})
                                : ({1'b0, r_pos[gi]} - {1'b0, player_left});
            assign w_dist_r[gi] = (player_right >= r_pos[gi])
                                ? ({1'b0, player_right} - {1'b0, r_pos[gi]})
                                : ({1'b0, r_pos[gi]} - {1'b0, player_right});
            assign w_hit_l[gi]     = r_active[gi] && (w_dist_l[gi] <= c_RADIUS);
            assign w_hit_r[gi]     = r_active[gi] && (w_dist_r[gi] <= c_RADIUS);
            assign w_can_spawn[gi] = !r_active[gi] && (r_rsp[gi] == '0);
            assign coin_pos[gi*POS_W +: POS_W] = r_pos[gi];
        end
    endgenerate

    // Lowest set bit selects the lowest-index candidate slot
    assign w_first_l  = w_hit_l & (~w_hit_l + c_SLOT_ONE);
    assign w_first_r  = w_hit_r & (~w_hit_r + c_SLOT_ONE);
    assign w_spawn_oh = w_can_spawn & (~w_can_spawn + c_SLOT_ONE);
    assign w_same     = w_first_l & w_first_r;

    always_comb begin
        w_right_closer = 1'b0;
        w_take_l       = w_first_l;
        w_take_r       = w_first_r;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (w_same[i] && (w_dist_r[i] < w_dist_l[i])) begin
                w_right_closer = 1'b1;
            end
        end
        // Contested slot: strictly closer right player wins, otherwise left
        if (|w_same) begin
            if (w_right_closer) begin
                w_take_l = '0;
            end else begin
                w_take_r = '0;
            end
        end
    end

    assign w_win_l = |w_take_l;
    assign w_win_r = |w_take_r;

`ifdef COIN_EXPIRE_EN
    localparam int                  c_LIFE_W    = (LIFE_TICKS > 1) ? $clog2(LIFE_TICKS) : 1;
    localparam logic [c_LIFE_W-1:0] c_LIFE_LOAD = c_LIFE_W'(LIFE_TICKS - 1);
    localparam logic [c_LIFE_W-1:0] c_LIFE_ONE  = c_LIFE_W'(1);

    logic [c_LIFE_W-1:0] r_life [NUM_COINS];

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_life
            assign w_expire[gi] = r_active[gi] && (r_life[gi] == '0)
                                && !w_take_l[gi] && !w_take_r[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                r_life[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (w_spawn_oh[i]) begin
                    r_life[i] <= c_LIFE_LOAD;
                end else if (r_active[i] && (r_life[i] != '0)) begin
                    r_life[i] <= r_life[i] - c_LIFE_ONE;
                end
            end
        end
    end
`else
    assign w_expire = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            for (int i = 0; i < NUM_COINS; i++) begin
                r_pos[i] <= '0;
                r_rsp[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (r_active[i]) begin
                    if (w_take_l[i] || w_take_r[i] || w_expire[i]) begin
                        r_active[i] <= 1'b0;
                        r_rsp[i]    <= c_RSP_LOAD;
                    end
                end else if (w_spawn_oh[i]) begin
                    r_active[i] <= 1'b1;
                    r_pos[i]    <= w_spawn_pos;
                end else if (r_rsp[i] != '0) begin
                    r_rsp[i] <= r_rsp[i] - c_RSP_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collect_left  <= 1'b0;
            r_collect_right <= 1'b0;
            r_score_left    <= '0;
            r_score_right   <= '0;
        end else begin
            r_collect_left  <= tick && w_win_l;
            r_collect_right <= tick && w_win_r;
            if (tick && w_win_l && (r_score_left != c_SCORE_MAX)) begin
                r_score_left <= r_score_left + c_SCORE_ONE;
            end
            if (tick && w_win_r && (r_score_right != c_SCORE_MAX)) begin
                r_score_right <= r_score_right + c_SCORE_ONE;
            end
        end
    end

    assign coin_active   = r_active;
    assign collect_left  = r_collect_left;
    assign collect_right = r_collect_right;
    assign score_left    = r_score_left;
    assign score_right   = r_score_right;

endmodule
`default_nettype wire

// File: tb/tb_coin_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_field
// Purpose  : Directed, table-driven bench for coin_field (one-slot and
//            four-slot instances sharing clock and reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_field;

    localparam int FAR = 1000;  // offset sentinel: player parked at 1023

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick1 = 1'b0;
    logic        tick4 = 1'b0;
    logic [9:0]  pl1 = '0, pr1 = '0, pl4 = '0, pr4 = '0;

    logic [0:0]  act1;
    logic [9:0]  pos1;
    logic        cl1, cr1;
    logic [3:0]  sl1, sr1;
    logic [3:0]  act4;
    logic [39:0] pos4;
    logic        cl4, cr4;
    logic [3:0]  sl4, sr4;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_lfsr;
    logic        have1;
    logic [9:0]  x1;

    typedef struct {
        int   off_l;
        int   off_r;
        logic exp_cl;
        logic exp_cr;
        int   exp_sl;
        int   exp_sr;
    } rec_t;

    typedef struct {
        logic [3:0] mask;
        int         slot;
    } step_t;

    coin_field #(
        .NUM_COINS(1), .POS_W(10), .FIELD_MAX(639), .HIT_RADIUS(8),
        .LIFE_TICKS(180), .RESPAWN_TICKS(2), .SCORE_W(4)
    ) u_one (
        .clk(clk), .rst(rst), .tick(tick1),
        .player_left(pl1), .player_right(pr1),
        .coin_active(act1), .coin_pos(pos1),
        .collect_left(cl1), .collect_right(cr1),
        .score_left(sl1), .score_right(sr1)
    );

    coin_field #(
        .NUM_COINS(4), .POS_W(10), .FIELD_MAX(639), .HIT_RADIUS(8),
        .LIFE_TICKS(3), .RESPAWN_TICKS(4), .SCORE_W(4)
    ) u_four (
        .clk(clk), .rst(rst), .tick(tick4),
        .player_left(pl4), .player_right(pr4),
        .coin_active(act4), .coin_pos(pos4),
        .collect_left(cl4), .collect_right(cr4),
        .score_left(sl4), .score_right(sr4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [9:0] fold(input logic [15:0] l);
        logic [9:0] p;
        p = l[9:0];
        return (p > 10'd639) ? (p - 10'd640) : p;
    endfunction

    function automatic logic [9:0] place(input int x, input int off);
        int p;
        if (off == FAR) return 10'd1023;
        p = x + off;
        if (p < 0) p = x - off;
        return p[9:0];
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One tick cycle on the chosen instance; returns the predicted spawn position
    task automatic do_tick(input int which, input logic [9:0] l, input logic [9:0] r,
                           output logic [9:0] sp);
        @(negedge clk);
        sp = fold(m_lfsr);
        if (which == 1) begin
            pl1 = l; pr1 = r; tick1 = 1'b1;
        end else begin
            pl4 = l; pr4 = r; tick4 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        tick1 = 1'b0;
        tick4 = 1'b0;
    endtask

    task automatic ensure_coin_one();
        logic [9:0] sp;
        if (!have1) begin
            do_tick(1, 10'd1023, 10'd1023, sp);
            check("one_spawn_active", act1, 1'b1);
            check("one_spawn_pos", pos1, sp);
            x1    = sp;
            have1 = 1'b1;
        end
    endtask

    task automatic pickup_one(input int off_l, input int off_r, input logic ecl,
                              input logic ecr, input int esl, input int esr);
        logic [9:0] sp;
        ensure_coin_one();
        do_tick(1, place(int'(x1), off_l), place(int'(x1), off_r), sp);
        check("one_collect_left", cl1, ecl);
        check("one_collect_right", cr1, ecr);
        check("one_score_left", sl1, esl[3:0]);
        check("one_score_right", sr1, esr[3:0]);
        check("one_active_after", act1, !(ecl || ecr));
        @(posedge clk);
        @(negedge clk);
        check("one_pulse_width", {cl1, cr1}, 2'b00);
        if (ecl || ecr) begin
            have1 = 1'b0;
            do_tick(1, 10'd1023, 10'd1023, sp);
            check("one_respawn_wait", act1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rec_t       recs[10];
        logic [9:0] sp;
        logic [9:0] exp_pos[4];
        logic [9:0] p0;
`ifdef COIN_EXPIRE_EN
        step_t      steps[7];
`else
        step_t      steps[3];
`endif

        recs[0] = '{8,   FAR, 1'b1, 1'b0, 1, 0};
        recs[1] = '{9,   FAR, 1'b0, 1'b0, 1, 0};
        recs[2] = '{-8,  FAR, 1'b1, 1'b0, 2, 0};
        recs[3] = '{5,   -5,  1'b1, 1'b0, 3, 0};
        recs[4] = '{5,   -4,  1'b0, 1'b1, 3, 1};
        recs[5] = '{FAR, 8,   1'b0, 1'b1, 3, 2};
        recs[6] = '{0,   0,   1'b1, 1'b0, 4, 2};
        recs[7] = '{-9,  9,   1'b0, 1'b0, 4, 2};
        recs[8] = '{3,   9,   1'b1, 1'b0, 5, 2};
        recs[9] = '{9,   2,   1'b0, 1'b1, 5, 3};
`ifdef COIN_EXPIRE_EN
        steps[0] = '{4'b0011, 1};
        steps[1] = '{4'b0111, 2};
        steps[2] = '{4'b1110, 3};
        steps[3] = '{4'b1100, -1};
        steps[4] = '{4'b1000, -1};
        steps[5] = '{4'b0000, -1};
        steps[6] = '{4'b0001, 0};
`else
        steps[0] = '{4'b0011, 1};
        steps[1] = '{4'b0111, 2};
        steps[2] = '{4'b1111, 3};
`endif
        have1 = 1'b0;
        x1    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_active4", act4, 4'b0000);
        check("rst_pos4", pos4, 40'd0);
        check("rst_scores4", {sl4, sr4}, 8'd0);
        check("rst_collect", {cl1, cr1, cl4, cr4}, 4'b0000);
        check("rst_active1", act1, 1'b0);
        rst = 1'b0;

        // First tick after reset spawns slot 0
        do_tick(4, 10'd0, 10'd639, sp);
        check("first_active", act4, 4'b0001);
        check("first_pos", pos4[9:0], sp);
        check("first_no_collect", {cl4, cr4}, 2'b00);
        exp_pos[0] = sp;

        foreach (steps[s]) begin
            do_tick(4, 10'd1023, 10'd1023, sp);
            check("four_mask", act4, steps[s].mask);
            check("four_no_collect", {cl4, cr4}, 2'b00);
            if (steps[s].slot >= 0) begin
                check("four_spawn_pos", pos4[steps[s].slot*10 +: 10], sp);
                exp_pos[steps[s].slot] = sp;
            end
        end
        p0 = exp_pos[0];

`ifndef COIN_EXPIRE_EN
        for (int t = 0; t < 1000; t++) begin
            do_tick(4, 10'd1023, 10'd1023, sp);
        end
        check("no_expire_active", act4, 4'b1111);
        for (int s = 0; s < 4; s++) begin
            check("no_expire_pos", pos4[s*10 +: 10], exp_pos[s]);
        end
`endif

        foreach (recs[r]) begin
            pickup_one(recs[r].off_l, recs[r].off_r, recs[r].exp_cl, recs[r].exp_cr,
                       recs[r].exp_sl, recs[r].exp_sr);
        end

        // Left score climbs to 15 and saturates while the pulse keeps firing
        for (int k = 1; k <= 11; k++) begin
            pickup_one(1, FAR, 1'b1, 1'b0, (5 + k > 15) ? 15 : 5 + k, 3);
        end

        // Reset coinciding with a pickup tick on an active coin
        @(negedge clk);
        rst   = 1'b1;
        tick4 = 1'b1;
        pl4   = p0;
        pr4   = 10'd1023;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        tick4 = 1'b0;
        check("midrst_active4", act4, 4'b0000);
        check("midrst_pos4", pos4, 40'd0);
        check("midrst_collect4", {cl4, cr4}, 2'b00);
        check("midrst_scores1", {sl1, sr1}, 8'd0);
        check("midrst_active1", act1, 1'b0);

        do_tick(4, 10'd1023, 10'd1023, sp);
        check("reseed_active", act4, 4'b0001);
        check("reseed_pos", pos4[9:0], sp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coin_field.md
# coin_field

Parametrised coin manager for the two-player game: holds NUM_COINS coin slots, spawns coins at pseudo-random horizontal positions, detects pickup against both player positions, optionally expires uncollected coins, and keeps a saturating score per player. It sits between the player position registers and the VGA renderer/score display. All state advances only on the one-cycle frame `tick`.

## Interface
- NUM_COINS, 4, number of coin slots (1..8)
- POS_W, 10, width of every horizontal position
- FIELD_MAX, 639, largest legal coin position; must satisfy 2^(POS_W-1)-1 <= FIELD_MAX <= 2^POS_W-1
- HIT_RADIUS, 8, pickup distance in pixels, inclusive
- LIFE_TICKS, 180, ticks a coin stays active before expiry (with COIN_EXPIRE_EN)
- RESPAWN_TICKS, 60, ticks a slot stays empty after collection or expiry
- SCORE_W, 4, score counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame strobe; all game updates happen on cycles with tick=1
- player_left  in  POS_W  left player position
- player_right  in  POS_W  right player position
- coin_active  out  NUM_COINS  bit i = slot i holds a live coin
- coin_pos  out  NUM_COINS*POS_W  slot i position at bits [i*POS_W +: POS_W]
- collect_left  out  1  one-cycle pulse: left player took a coin
- collect_right  out  1  one-cycle pulse: right player took a coin
- score_left  out  SCORE_W  left score, saturating
- score_right  out  SCORE_W  right score, saturating

## Operation
- Per-slot states: EMPTY (respawn countdown) -> ACTIVE (life countdown) -> EMPTY.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset; advances every clk, tick or not.
- Spawn: on a tick, the lowest-index EMPTY slot whose respawn counter is 0 becomes ACTIVE; at most one spawn per tick. Position p = lfsr[POS_W-1:0]; if p > FIELD_MAX, use p-(FIELD_MAX+1). Life counter loads LIFE_TICKS-1.
- Distance: |player - coin_pos|, unsigned, computed at POS_W+1 bits; hit when distance <= HIT_RADIUS.
- Pickup per tick, ACTIVE slots only: each player collects at most one coin, the lowest-index slot in range. If both players target the same slot, the smaller distance wins; a tie goes to left. The loser collects nothing that tick.
- A collected slot goes EMPTY and its respawn counter loads RESPAWN_TICKS-1. The collector's score increments and holds at 2^SCORE_W-1. The collect_* pulse asserts for that cycle.
- Expiry (with COIN_EXPIRE_EN): an ACTIVE slot whose life counter is 0 on a tick and is not collected that tick goes EMPTY and loads respawn. Pickup takes priority over expiry in the same tick.
- A slot spawned on a tick cannot be collected or expire until the next tick.
- Counters decrement only on ticks and stop at 0.

## Timing
- Reset: all slots EMPTY with respawn counters 0; coin_active=0, coin_pos=0, collect_*=0, scores=0, LFSR=16'hACE1.
- With tick=1 in cycle N, coin_active, coin_pos, scores and the collect_* pulses are registered and visible in cycle N+1.
- collect_* is high exactly one cycle and is never high when tick was low in the previous cycle.
- First coin: slot 0 spawns on the first tick after reset is released.
- rst asserted mid-game takes effect at the next clk edge and overrides tick; no pulse is emitted on that edge.
- Player positions are sampled in the tick cycle itself; changes between ticks are ignored.

## Configuration
- COIN_EXPIRE_EN defined: life counters are built in and coins expire after LIFE_TICKS ticks as described.
- COIN_EXPIRE_EN undefined: no life counters are built; a coin stays ACTIVE until collected, and LIFE_TICKS is unused.

## Test plan
- Reset, then 1 tick with players at 0 and 639 -> coin_active=4'b0001 one cycle later; coin_pos[9:0] = (16'hACE1 advanced per the reset-to-tick cycle count)[9:0], folded if > 639.
- Slot 0 at position x, player_left=x+8, tick -> collect_left pulses once; score_left=1; coin_active[0]=0. With player_left=x+9 instead -> no pickup.
- Both players 5 px from the same coin -> left wins. Right at 4 px, left at 5 px -> right wins, and right's score is the only one that increments.
- Left score at 15, then one more pickup -> score_left stays 15 and collect_left still pulses.
- With COIN_EXPIRE_EN and LIFE_TICKS=3: coin not touched -> inactive after the 3rd tick following spawn, then respawns after RESPAWN_TICKS ticks. Without the macro -> still active after 1000 ticks.
- Assert rst for one cycle while 4 coins are active and a pickup tick coincides -> all outputs 0 the next cycle and no collect pulse.
